// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter for the register-map local bus. One access
// is in flight at a time; a watchdog aborts accesses the slave never finishes.
module lb_arbiter #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 16,
  parameter int              STRB_W   = DATA_W/8,
  parameter int              TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hdead
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wen,
  output logic              m0_wready,
  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic              m0_ren,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wen,
  output logic              m1_wready,
  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic              m1_ren,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam int         CNT_W   = $clog2(TIMEOUT + 1);

  logic [1:0]        r_state;
  logic              r_owner;   // 0 = m0, 1 = m1
  logic              r_rr;      // 0 = m0 favoured on contention
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic              w_pend0, w_pend1, w_sel, w_sel_wen;
  logic              w_wr, w_rd, w_expired, w_end_wr, w_end_rd;
  logic [DATA_W-1:0] w_rd_data;

  assign w_pend0   = m0_wen | m0_ren;
  assign w_pend1   = m1_wen | m1_ren;
  assign w_sel     = (w_pend0 && w_pend1) ? r_rr : w_pend1;
  assign w_sel_wen = w_sel ? m1_wen : m0_wen;

  assign w_wr      = (r_state == S_WRITE);
  assign w_rd      = (r_state == S_READ);
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
  // Completion and expiry in the same cycle both end the access; the error
  // flag and the read data below only reflect expiry when completion is absent.
  assign w_end_wr  = w_wr && (lb_wready || w_expired);
  assign w_end_rd  = w_rd && (lb_rvalid || w_expired);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pend0 || w_pend1) begin
            r_owner <= w_sel;
            r_rr    <= ~w_sel;
            r_cnt   <= '0;
            if (w_sel_wen) begin
              r_state <= S_WRITE;
              r_addr  <= w_sel ? m1_waddr : m0_waddr;
              r_wdata <= w_sel ? m1_wdata : m0_wdata;
              r_wstrb <= w_sel ? m1_wstrb : m0_wstrb;
            end else begin
              r_state <= S_READ;
              r_addr  <= w_sel ? m1_raddr : m0_raddr;
            end
          end
        end
        S_WRITE, S_READ: begin
          if (w_end_wr || w_end_rd) r_state <= S_IDLE;
          else                      r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lb_wen   = w_wr;
  assign lb_ren   = w_rd;
  assign lb_waddr = w_wr ? r_addr  : '0;
  assign lb_wdata = w_wr ? r_wdata : '0;
  assign lb_wstrb = w_wr ? r_wstrb : '0;
  assign lb_raddr = w_rd ? r_addr  : '0;

  assign grant = {(w_wr | w_rd) & r_owner, (w_wr | w_rd) & ~r_owner};

  assign w_rd_data = lb_rvalid ? lb_rdata : ERR_DATA;

  assign m0_wready = w_end_wr & ~r_owner;
  assign m1_wready = w_end_wr &  r_owner;
  assign m0_rvalid = w_end_rd & ~r_owner;
  assign m1_rvalid = w_end_rd &  r_owner;
  assign m0_rdata  = m0_rvalid ? w_rd_data : '0;
  assign m1_rdata  = m1_rvalid ? w_rd_data : '0;

  assign timeout_err = w_expired && ((w_wr && !lb_wready) || (w_rd && !lb_rvalid));

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter: expected completions are queued by the
// stimulus and popped by a monitor whenever a master sees wready/rvalid.
module tb_lb_arbiter;
  localparam int AW = 8, DW = 16, SW = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m_waddr[2], m_raddr[2];
  logic [DW-1:0] m_wdata[2];
  logic [SW-1:0] m_wstrb[2];
  logic          m_wen[2], m_ren[2];
  logic          wready0, wready1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] lb_waddr, lb_raddr;
  logic [DW-1:0] lb_wdata, lb_rdata;
  logic [SW-1:0] lb_wstrb;
  logic          lb_wen, lb_ren, lb_wready, lb_rvalid, timeout_err;
  logic [1:0]    grant;

  // slave model: rvalid on the s_delay-th cycle of lb_ren, data = s_base + reads so far
  logic          s_wready;
  int            s_delay, s_cnt, s_nread;
  logic [DW-1:0] s_base;
  assign lb_wready = s_wready;
  assign lb_rvalid = lb_ren && (s_cnt == s_delay - 1);
  assign lb_rdata  = s_base + DW'(s_nread);
  always @(posedge clk) begin
    s_cnt <= (!lb_ren || lb_rvalid) ? 0 : s_cnt + 1;
    if (lb_ren && lb_rvalid) s_nread <= s_nread + 1;
  end
  initial begin s_cnt = 0; s_nread = 0; end

  lb_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_waddr(m_waddr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wen(m_wen[0]),
    .m0_wready(wready0), .m0_raddr(m_raddr[0]), .m0_ren(m_ren[0]), .m0_rdata(rdata0), .m0_rvalid(rvalid0),
    .m1_waddr(m_waddr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wen(m_wen[1]),
    .m1_wready(wready1), .m1_raddr(m_raddr[1]), .m1_ren(m_ren[1]), .m1_rdata(rdata1), .m1_rvalid(rvalid1),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen), .lb_wready(lb_wready),
    .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
    .grant(grant), .timeout_err(timeout_err)
  );

  // second instance with a short watchdog and a slave that never answers
  logic [AW-1:0] t_raddr, t_lb_waddr, t_lb_raddr;
  logic          t_ren, t_wready0, t_wready1, t_rvalid0, t_rvalid1, t_lb_wen, t_lb_ren, t_terr;
  logic [DW-1:0] t_rdata0, t_rdata1, t_lb_wdata;
  logic [SW-1:0] t_lb_wstrb;
  logic [1:0]    t_grant;
  lb_arbiter #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .m0_waddr('0), .m0_wdata('0), .m0_wstrb('0), .m0_wen(1'b0),
    .m0_wready(t_wready0), .m0_raddr(t_raddr), .m0_ren(t_ren), .m0_rdata(t_rdata0), .m0_rvalid(t_rvalid0),
    .m1_waddr('0), .m1_wdata('0), .m1_wstrb('0), .m1_wen(1'b0),
    .m1_wready(t_wready1), .m1_raddr('0), .m1_ren(1'b0), .m1_rdata(t_rdata1), .m1_rvalid(t_rvalid1),
    .lb_waddr(t_lb_waddr), .lb_wdata(t_lb_wdata), .lb_wstrb(t_lb_wstrb), .lb_wen(t_lb_wen), .lb_wready(1'b0),
    .lb_raddr(t_lb_raddr), .lb_ren(t_lb_ren), .lb_rdata(16'h5555), .lb_rvalid(1'b0),
    .grant(t_grant), .timeout_err(t_terr)
  );

  typedef struct { bit rd; logic [DW-1:0] data; bit err; } exp_t;
  exp_t q0[$], q1[$], qt[$];
  int   gq[$];
  int   n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int m, input bit rd, input logic [DW-1:0] d, input bit err);
    exp_t e;
    e.rd = rd; e.data = d; e.err = err;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    gq.push_back(m);
  endtask

  task automatic wait_sig(input int which, input string name);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = wready0;
        1: hit = wready1;
        2: hit = rvalid0;
        default: hit = rvalid1;
      endcase
    end
    check(name, 32'(hit), 1);
  endtask

  task automatic do_write(input int m);
    m_wen[m] = 1'b1;
    wait_sig(m, "wr_done");
    m_wen[m] = 1'b0;
  endtask

  task automatic rd_loop(input int m, input int n);
    m_ren[m] = 1'b1;
    repeat (n) wait_sig(2 + m, "rd_done");
    m_ren[m] = 1'b0;
  endtask

  // main-instance monitor
  always @(negedge clk) begin
    if (!rst) check("bus_exclusive", 32'(lb_wen & lb_ren), 0);
    for (int m = 0; m < 2; m++) begin
      logic wr_p, rd_p;
      logic [DW-1:0] rd_d;
      exp_t e;
      wr_p = (m == 0) ? wready0 : wready1;
      rd_p = (m == 0) ? rvalid0 : rvalid1;
      rd_d = (m == 0) ? rdata0  : rdata1;
      if (!rd_p) check("rdata_quiet", 32'(rd_d), 0);
      if (wr_p || rd_p) begin
        if ((m == 0 ? q0.size() : q1.size()) == 0 || gq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: m%0d wready=%0b rvalid=%0b expected none", m, wr_p, rd_p);
        end else begin
          e = (m == 0) ? q0.pop_front() : q1.pop_front();
          check("grant_order", 32'(m), 32'(gq.pop_front()));
          check("resp_kind", {30'd0, wr_p, rd_p}, e.rd ? 32'd1 : 32'd2);
          if (e.rd) check("resp_data", 32'(rd_d), 32'(e.data));
          check("resp_err", 32'(timeout_err), 32'(e.err));
          check("resp_grant", 32'(grant), (m == 0) ? 32'd1 : 32'd2);
        end
      end
    end
  end

  // watchdog-instance monitor
  always @(negedge clk) begin
    exp_t e;
    if (t_rvalid0) begin
      if (qt.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_to_resp: rdata=%0h expected none", t_rdata0);
      end else begin
        e = qt.pop_front();
        check("to_data", 32'(t_rdata0), 32'(e.data));
        check("to_err", 32'(t_terr), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: sim still running, expected finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int cnt;
    bit m1seen;
    for (int m = 0; m < 2; m++) begin
      m_waddr[m] = '0; m_raddr[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0;
      m_wen[m] = 1'b0; m_ren[m] = 1'b0;
    end
    s_wready = 1'b1; s_delay = 2; s_base = 16'h1000;
    t_ren = 1'b0; t_raddr = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_lb_en", {30'd0, lb_wen, lb_ren}, 0);
    check("rst_resp", {28'd0, wready0, wready1, rvalid0, rvalid1}, 0);
    check("rst_terr", 32'(timeout_err), 0);
    rst = 1'b0;

    // m0 single write, wready tied high
    m_waddr[0] = 8'h00; m_wdata[0] = 16'h0111; m_wstrb[0] = 2'b11; m_wen[0] = 1'b1;
    push_exp(0, 0, '0, 0);
    check("w_c0_lb_wen", 32'(lb_wen), 0);
    @(negedge clk);
    check("w_c1_lb_wen", 32'(lb_wen), 1);
    check("w_c1_waddr", 32'(lb_waddr), 0);
    check("w_c1_wdata", 32'(lb_wdata), 32'h0111);
    check("w_c1_wstrb", 32'(lb_wstrb), 3);
    check("w_c1_wready", 32'(wready0), 1);
    m_wen[0] = 1'b0;
    @(negedge clk);
    check("w_c2_grant", 32'(grant), 0);
    check("w_c2_lb_wen", 32'(lb_wen), 0);

    // m1 wen+ren together: write first, idle gap, then read
    m_waddr[1] = 8'h22; m_wdata[1] = 16'h2222; m_wstrb[1] = 2'b01; m_raddr[1] = 8'h33;
    m_wen[1] = 1'b1; m_ren[1] = 1'b1;
    push_exp(1, 0, '0, 0);
    push_exp(1, 1, 16'h1000, 0);
    wait_sig(1, "wr_ren_wdone");
    check("wr_ren_waddr", 32'(lb_waddr), 32'h22);
    check("wr_ren_wstrb", 32'(lb_wstrb), 1);
    m_wen[1] = 1'b0;
    @(negedge clk);
    check("wr_ren_gap_grant", 32'(grant), 0);
    @(negedge clk);
    check("wr_ren_lb_ren", 32'(lb_ren), 1);
    check("wr_ren_raddr", 32'(lb_raddr), 32'h33);
    wait_sig(3, "wr_ren_rdone");
    m_ren[1] = 1'b0;
    @(negedge clk);

    // contention: both read 0x4 continuously, expect m0,m1,m0,m1
    m_raddr[0] = 8'h04; m_raddr[1] = 8'h04;
    push_exp(0, 1, 16'h1001, 0);
    push_exp(1, 1, 16'h1002, 0);
    push_exp(0, 1, 16'h1003, 0);
    push_exp(1, 1, 16'h1004, 0);
    fork
      rd_loop(0, 2);
      rd_loop(1, 2);
    join
    @(negedge clk);

    // slow slave: rvalid on the 10th lb_ren cycle; five reads done so far
    s_delay = 10; s_base = 16'h0abc - 16'd5;
    m_raddr[0] = 8'h40; m_ren[0] = 1'b1;
    push_exp(0, 1, 16'h0abc, 0);
    cnt = 0; m1seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lb_ren) cnt++;
      if (rvalid1) m1seen = 1;
      if (rvalid0) break;
    end
    m_ren[0] = 1'b0;
    check("slow_ren_cycles", 32'(cnt), 10);
    check("slow_m1_rvalid", 32'(m1seen), 0);

    // watchdog: TIMEOUT=8, slave silent
    t_raddr = 8'h10; t_ren = 1'b1;
    qt.push_back('{rd: 1'b1, data: 16'hdead, err: 1'b1});
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (t_lb_ren) cnt++;
      if (t_rvalid0) break;
    end
    t_ren = 1'b0;
    check("to_ren_cycles", 32'(cnt), 8);
    @(negedge clk);
    check("to_after_lb_ren", 32'(t_lb_ren), 0);
    check("to_after_grant", 32'(t_grant), 0);
    check("to_after_terr", 32'(t_terr), 0);

    // reset in the middle of a read
    s_delay = 20;
    m_raddr[0] = 8'h55; m_ren[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_in_read", 32'(lb_ren), 1);
    rst = 1'b1; m_ren[0] = 1'b0;
    @(negedge clk);
    check("rstmid_grant", 32'(grant), 0);
    check("rstmid_lb", {30'd0, lb_wen, lb_ren}, 0);
    check("rstmid_raddr", 32'(lb_raddr), 0);
    check("rstmid_resp", {27'd0, wready0, wready1, rvalid0, rvalid1, timeout_err}, 0);
    rst = 1'b0;

    // pointer back at reset value: simultaneous writes go m0 then m1
    m_waddr[0] = 8'h60; m_wdata[0] = 16'h6000; m_wstrb[0] = 2'b11;
    m_waddr[1] = 8'h61; m_wdata[1] = 16'h6161; m_wstrb[1] = 2'b10;
    push_exp(0, 0, '0, 0);
    push_exp(1, 0, '0, 0);
    fork
      do_write(0);
      do_write(1);
    join
    m_waddr[1] = 8'h70;
    push_exp(1, 0, '0, 0);
    do_write(1);

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(q0.size() + q1.size() + qt.size() + gq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
